// File: rtl/dmem_pair_reader.sv
// dmem_pair_reader: issues one dual read per cycle against the dual-read data
// memory and streams the returned word pairs out through a small FIFO.
// Port A reads base+4*i; port B reads base+4*i+offset, which the memory forms
// from Address+WriteData.
module dmem_pair_reader #(
    parameter int CNT_W     = 10,
    parameter int OUT_DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      offset,
    input  logic [CNT_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [31:0]      EX_MEM_Address,
    output logic [31:0]      EX_MEM_WriteData,
    output logic             EX_MEM_MemRead,
    output logic             EX_MEM_MemWrite,
    output logic             EX_MEM_HalfControl,
    output logic             EX_MEM_ByteControl,
    input  logic [31:0]      MEM_ReadData_A,
    input  logic [31:0]      MEM_ReadData_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data_a,
    output logic [31:0]      out_data_b,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last
);

    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_FW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state, next_state;
    logic [31:0]        base_q;
    logic [31:0]        off_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   idx;
    logic [31:0]        last_addr;
    logic               zero_done;

    // Output FIFO storage and bookkeeping
    logic [31:0]        fifo_a    [OUT_DEPTH];
    logic [31:0]        fifo_b    [OUT_DEPTH];
    logic [CNT_W-1:0]   fifo_idx  [OUT_DEPTH];
    logic               fifo_last [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_FW-1:0]  fcount;

    logic               fifo_full;
    logic               issue;
    logic               pop;
    logic               is_last_idx;
    logic               done_drain;
    logic [31:0]        issue_addr;

    // Issue decisions depend only on registered state, idx and FIFO count,
    // so neither out_ready nor start reaches the memory outputs combinationally.
    assign fifo_full   = (fcount == CNT_FW'(OUT_DEPTH));
    assign issue       = (state == S_ISSUE) && !fifo_full;
    assign is_last_idx = (idx == len_q - CNT_W'(1));
    assign issue_addr  = base_q + 32'({idx, 2'b00});
    assign pop         = out_valid && out_ready;

    assign busy               = (state != S_IDLE);
    assign done               = done_drain || zero_done;
    assign EX_MEM_MemRead     = issue;
    assign EX_MEM_Address     = issue ? issue_addr : last_addr;
    assign EX_MEM_WriteData   = off_q;
    assign EX_MEM_MemWrite    = 1'b0;
    assign EX_MEM_HalfControl = 1'b0;
    assign EX_MEM_ByteControl = 1'b0;

    assign out_valid  = (fcount != '0);
    assign out_data_a = fifo_a[rd_ptr];
    assign out_data_b = fifo_b[rd_ptr];
    assign out_index  = fifo_idx[rd_ptr];
    assign out_last   = fifo_last[rd_ptr];

    // Next-state logic and the end-of-run done pulse
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        done_drain = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (length != '0)) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue && is_last_idx) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fcount == '0) begin
                    done_drain = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Control state: FSM, run parameters, pair index, FIFO pointers and count
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (Reset) begin
            state     <= S_IDLE;
            base_q    <= '0;
            off_q     <= '0;
            len_q     <= '0;
            idx       <= '0;
            last_addr <= '0;
            zero_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcount    <= '0;
        end else begin
            state     <= next_state;
            zero_done <= (state == S_IDLE) && start && (length == '0);

            if ((state == S_IDLE) && start && (length != '0)) begin
                base_q <= base_addr;
                off_q  <= offset;
                len_q  <= length;
                idx    <= '0;
            end

            if (issue) begin
                idx       <= idx + CNT_W'(1);
                last_addr <= issue_addr;
                wr_ptr    <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({issue, pop})
                2'b10:   fcount <= fcount + CNT_FW'(1);
                2'b01:   fcount <= fcount - CNT_FW'(1);
                default: fcount <= fcount;
            endcase
        end
    end

    // Capture the returned word pair at the edge that ends its issue cycle
    always_ff @(posedge Clk) begin
        // NOTE: FIFO storage is not reset; the count alone decides which entries are meaningful.
        if (issue) begin
            fifo_a[wr_ptr]    <= MEM_ReadData_A;
            fifo_b[wr_ptr]    <= MEM_ReadData_B;
            fifo_idx[wr_ptr]  <= idx;
            fifo_last[wr_ptr] <= is_last_idx;
        end
    end

endmodule

// File: tb/tb_dmem_pair_reader.sv
// tb_dmem_pair_reader: directed scoreboard bench for dmem_pair_reader.
// Stimulus pushes hand-computed expected pairs; a negedge monitor pops and
// compares whenever the DUT hands a pair over.
module tb_dmem_pair_reader;

    localparam int CNT_W     = 10;
    localparam int OUT_DEPTH = 2;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [CNT_W-1:0] idx;
        logic             last;
    } pair_t;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [31:0]      offset;
    logic [CNT_W-1:0] length;
    logic             busy;
    logic             done;
    logic [31:0]      EX_MEM_Address;
    logic [31:0]      EX_MEM_WriteData;
    logic             EX_MEM_MemRead;
    logic             EX_MEM_MemWrite;
    logic             EX_MEM_HalfControl;
    logic             EX_MEM_ByteControl;
    logic [31:0]      MEM_ReadData_A;
    logic [31:0]      MEM_ReadData_B;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data_a;
    logic [31:0]      out_data_b;
    logic [CNT_W-1:0] out_index;
    logic             out_last;

    dmem_pair_reader #(.CNT_W(CNT_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .start              (start),
        .base_addr          (base_addr),
        .offset             (offset),
        .length             (length),
        .busy               (busy),
        .done               (done),
        .EX_MEM_Address     (EX_MEM_Address),
        .EX_MEM_WriteData   (EX_MEM_WriteData),
        .EX_MEM_MemRead     (EX_MEM_MemRead),
        .EX_MEM_MemWrite    (EX_MEM_MemWrite),
        .EX_MEM_HalfControl (EX_MEM_HalfControl),
        .EX_MEM_ByteControl (EX_MEM_ByteControl),
        .MEM_ReadData_A     (MEM_ReadData_A),
        .MEM_ReadData_B     (MEM_ReadData_B),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data_a         (out_data_a),
        .out_data_b         (out_data_b),
        .out_index          (out_index),
        .out_last           (out_last)
    );

    always #5 Clk = ~Clk;

    // Memory model: mem[k] = k, word-decoded on bits [11:2]
    logic [31:0] mem [1024];
    logic [31:0] b_addr;
    initial for (int k = 0; k < 1024; k++) mem[k] = k;
    always_comb begin
        b_addr         = EX_MEM_Address + EX_MEM_WriteData;
        MEM_ReadData_A = mem[EX_MEM_Address[11:2]];
        MEM_ReadData_B = mem[b_addr[11:2]];
    end

    int    checks   = 0;
    int    failures = 0;
    int    cycle    = 0;
    int    pops     = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    mr_cnt   = 0;
    int    mw_cnt   = 0;
    pair_t exp_q[$];
    int    pop_cyc[$];
    logic [31:0] addr_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(posedge Clk) cycle++;

    // Monitor: scoreboard pops, memory-side activity and done pulses
    always @(negedge Clk) begin
        pair_t got;
        pair_t e;
        if (!Reset) begin
            if (EX_MEM_MemRead) begin
                mr_cnt++;
                addr_log.push_back(EX_MEM_Address);
            end
            if (EX_MEM_MemWrite || EX_MEM_HalfControl || EX_MEM_ByteControl) mw_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cycle;
            end
            if (out_valid && out_ready) begin
                got = '{a: out_data_a, b: out_data_b, idx: out_index, last: out_last};
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", got, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", got, e);
                end
                pops++;
                pop_cyc.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_push(input int a, input int b, input int i, input bit last);
        exp_q.push_back('{a: a, b: b, idx: CNT_W'(i), last: last});
    endtask

    task automatic launch(input logic [31:0] b, input logic [31:0] o, input int len);
        start     = 1'b1;
        base_addr = b;
        offset    = o;
        length    = CNT_W'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check(name, done_cnt != d0, 1'b1);
    endtask

    initial begin
        int p0, d0, m0;
        Reset = 1'b1; start = 1'b0; base_addr = '0; offset = '0; length = '0; out_ready = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_memread", EX_MEM_MemRead, 1'b0);
        check("rst_addr", EX_MEM_Address, 32'h0);
        check("rst_wdata", EX_MEM_WriteData, 32'h0);

        // 1: base 0x40, offset 0x10, 4 pairs, ready held high
        exp_push(16, 20, 0, 0); exp_push(17, 21, 1, 0);
        exp_push(18, 22, 2, 0); exp_push(19, 23, 3, 1);
        pop_cyc.delete();
        launch(32'h40, 32'h10, 4);
        check("t1_busy", busy, 1'b1);
        wait_done("t1_done", 40);
        check("t1_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            check("t1_consecutive", pop_cyc[3] - pop_cyc[0], 3);
            check("t1_done_lat", done_cyc - pop_cyc[3], 1);
        end
        tick();
        check("t1_idle", busy, 1'b0);

        // 2: same run, consumer stalled for 6 cycles
        exp_push(16, 20, 0, 0); exp_push(17, 21, 1, 0);
        exp_push(18, 22, 2, 0); exp_push(19, 23, 3, 1);
        out_ready = 1'b0;
        m0 = mr_cnt; p0 = pops;
        launch(32'h40, 32'h10, 4);
        repeat (6) tick();
        check("t2_stall_issues", mr_cnt - m0, 2);
        check("t2_stall_memread", EX_MEM_MemRead, 1'b0);
        check("t2_stall_addr_hold", EX_MEM_Address, 32'h44);
        check("t2_stall_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_done("t2_done", 40);
        check("t2_issues", mr_cnt - m0, 4);
        check("t2_pops", pops - p0, 4);
        tick();

        // 3: zero-length start
        m0 = mr_cnt;
        launch(32'h80, 32'h4, 0);
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b0);
        tick();
        check("t3_done_pulse", done, 1'b0);
        check("t3_no_memread", mr_cnt - m0, 0);

        // 4: A address wraps at 4 KB
        exp_push(1023, 0, 0, 0); exp_push(0, 1, 1, 1);
        addr_log.delete();
        launch(32'hFFC, 32'h4, 2);
        wait_done("t4_done", 40);
        check("t4_issues", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("t4_addr0", addr_log[0], 32'hFFC);
            check("t4_addr1", addr_log[1], 32'h1000);
        end
        tick();

        // 5: reset after 2 of 8 pops, then a fresh run
        exp_push(64, 66, 0, 0); exp_push(65, 67, 1, 0);
        exp_push(66, 68, 2, 0); exp_push(67, 69, 3, 0);
        exp_push(68, 70, 4, 0); exp_push(69, 71, 5, 0);
        exp_push(70, 72, 6, 0); exp_push(71, 73, 7, 1);
        p0 = pops; d0 = done_cnt;
        launch(32'h100, 32'h8, 8);
        for (int i = 0; i < 40 && (pops - p0) < 2; i++) tick();
        out_ready = 1'b0;
        Reset = 1'b1;
        tick();
        check("t5_valid", out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_pops", pops - p0, 2);
        Reset = 1'b0;
        exp_q.delete();
        tick(); tick();
        check("t5_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        exp_push(0, 8, 0, 0); exp_push(1, 9, 1, 0); exp_push(2, 10, 2, 1);
        launch(32'h0, 32'h20, 3);
        wait_done("t5_rerun_done", 40);
        tick();

        // 6: start pulsed mid-run is ignored
        exp_push(16, 20, 0, 0); exp_push(17, 21, 1, 0);
        exp_push(18, 22, 2, 0); exp_push(19, 23, 3, 1);
        p0 = pops; d0 = done_cnt;
        launch(32'h40, 32'h10, 4);
        launch(32'h200, 32'h8, 2);
        wait_done("t6_done", 40);
        repeat (4) tick();
        check("t6_pops", pops - p0, 4);
        check("t6_one_done", done_cnt - d0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        check("memwrite_never", mw_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
